sdram_req_bridge: RTL and testbench



---
 rtl/sdram_bridge_pkg.sv | 27 ++
 rtl/sdram_cmd_fifo.sv | 52 +++++
 rtl/sdram_req_bridge.sv | 159 +++++++++++++++
 tb/tb_sdram_req_bridge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bridge_pkg.sv
// Shared types for the SDRAM request bridge.
//   op_e    : command opcode (write / read)
//   cmd_t   : one buffered request {op, addr, wdata}
//   state_e : Avalon issue FSM states
// DEF_ADDR_W / DEF_DATA_W size cmd_t and are the default bridge widths.
package sdram_bridge_pkg;

  localparam int unsigned DEF_ADDR_W = 26;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/sdram_cmd_fifo.sv
// Show-ahead synchronous FIFO of cmd_t.
//   i_clk, i_rst_n : clock, async active-low reset (pointers only)
//   i_push, i_data : write an entry; ignored when full
//   i_pop          : drop the head entry; ignored when empty
//   o_head         : current head entry, valid while o_empty is low
//   o_full, o_empty: occupancy flags, combinational from the pointers
module sdram_cmd_fifo
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  cmd_t i_data,
  input  logic i_pop,
  output cmd_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty can be told apart.
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  cmd_t           mem_q [DEPTH];
  logic           push_ok, pop_ok;

  always_comb begin
    o_empty = (wr_ptr_q == rd_ptr_q);
    o_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    push_ok = i_push && !o_full;
    pop_ok  = i_pop && !o_empty;
    o_head  = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/sdram_req_bridge.sv
// Single-pulse SDRAM request responder -> Avalon-MM master.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_write/i_read/i_addr/i_wdata : one-cycle request pulses
//   o_rdata, o_rvalid       : registered read return, request order
//   o_full                  : command FIFO full (combinational)
//   o_drop                  : one-cycle pulse when a request is discarded
//   o_avm_*                 : Avalon-MM master towards the SDRAM controller
//   i_avm_waitrequest/readdata/readdatavalid : Avalon slave responses
module sdram_req_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAX_PEND_RD = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_write,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_full,
  output logic              o_drop,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_write,
  output logic              o_avm_read,
  output logic [DATA_W-1:0] o_avm_writedata,
  output logic [1:0]        o_avm_byteenable,
  input  logic              i_avm_waitrequest,
  input  logic [DATA_W-1:0] i_avm_readdata,
  input  logic              i_avm_readdatavalid
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND_RD + 1);
  localparam logic [PEND_W:0] MAX_PEND = (PEND_W + 1)'(MAX_PEND_RD);

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] avm_addr_q;
  logic [DATA_W-1:0] avm_wdata_q, rdata_q;
  logic              avm_write_q, avm_read_q, rvalid_q, drop_q;

  cmd_t              push_cmd, head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              req, drop_d;
  logic              xfer_done, rd_done, rd_ret, head_ok, load, clear;
  logic [PEND_W:0]   issue_cnt;

  sdram_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_data  (push_cmd),
    .i_pop   (fifo_pop),
    .o_head  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Request acceptance: a simultaneous write+read keeps the write. A full
  // FIFO rejects even when a pop happens on the same edge.
  always_comb begin
    req            = i_write | i_read;
    fifo_push      = req & ~fifo_full;
    push_cmd.op    = i_write ? OP_WR : OP_RD;
    push_cmd.addr  = i_addr;
    push_cmd.wdata = i_wdata;
    drop_d         = (req & fifo_full) | (i_write & i_read);
  end

  // Read-credit bookkeeping. A read may be loaded only if, counting a read
  // completing on this edge, fewer than MAX_PEND_RD are outstanding; the
  // loaded read then cannot push the count past the limit when it completes.
  always_comb begin
    xfer_done = (state_q == S_ISSUE) & ~i_avm_waitrequest;
    rd_done   = xfer_done & avm_read_q;
    rd_ret    = i_avm_readdatavalid & (pend_q != '0);
    issue_cnt = {1'b0, pend_q} + {{PEND_W{1'b0}}, rd_done};
    head_ok   = ~fifo_empty & ((head.op == OP_WR) | (issue_cnt < MAX_PEND));
    pend_d    = pend_q;
    if (rd_done && !rd_ret)      pend_d = pend_q + PEND_W'(1);
    else if (!rd_done && rd_ret) pend_d = pend_q - PEND_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (head_ok) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (xfer_done) begin
          if (head_ok) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
          end else begin
            clear   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      avm_addr_q  <= '0;
      avm_wdata_q <= '0;
      avm_write_q <= 1'b0;
      avm_read_q  <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rvalid_q <= rd_ret;
      drop_q   <= drop_d;
      if (rd_ret) rdata_q <= i_avm_readdata;
      if (load) begin
        avm_addr_q  <= head.addr;
        avm_wdata_q <= head.wdata;
        avm_write_q <= (head.op == OP_WR);
        avm_read_q  <= (head.op == OP_RD);
      end else if (clear) begin
        avm_write_q <= 1'b0;
        avm_read_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    o_full           = fifo_full;
    o_drop           = drop_q;
    o_rdata          = rdata_q;
    o_rvalid         = rvalid_q;
    o_avm_address    = avm_addr_q;
    o_avm_write      = avm_write_q;
    o_avm_read       = avm_read_q;
    o_avm_writedata  = avm_wdata_q;
    o_avm_byteenable = 2'b11;
  end

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed self-checking bench for sdram_req_bridge. Inputs change #1 after
// a rising edge; outputs are sampled at that same point.
module tb_sdram_req_bridge;

  logic        i_clk, i_rst_n;
  logic        i_write, i_read;
  logic [25:0] i_addr;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_rvalid, o_full, o_drop;
  logic [25:0] o_avm_address;
  logic        o_avm_write, o_avm_read;
  logic [15:0] o_avm_writedata;
  logic [1:0]  o_avm_byteenable;
  logic        i_avm_waitrequest;
  logic [15:0] i_avm_readdata;
  logic        i_avm_readdatavalid;

  int unsigned total = 0;
  int unsigned bad   = 0;

  sdram_req_bridge dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_write             (i_write),
    .i_read              (i_read),
    .i_addr              (i_addr),
    .i_wdata             (i_wdata),
    .o_rdata             (o_rdata),
    .o_rvalid            (o_rvalid),
    .o_full              (o_full),
    .o_drop              (o_drop),
    .o_avm_address       (o_avm_address),
    .o_avm_write         (o_avm_write),
    .o_avm_read          (o_avm_read),
    .o_avm_writedata     (o_avm_writedata),
    .o_avm_byteenable    (o_avm_byteenable),
    .i_avm_waitrequest   (i_avm_waitrequest),
    .i_avm_readdata      (i_avm_readdata),
    .i_avm_readdatavalid (i_avm_readdatavalid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".write"}, 32'(o_avm_write), 0);
    check({tag, ".read"}, 32'(o_avm_read), 0);
    check({tag, ".addr"}, 32'(o_avm_address), 0);
    check({tag, ".wdata"}, 32'(o_avm_writedata), 0);
    check({tag, ".rvalid"}, 32'(o_rvalid), 0);
    check({tag, ".rdata"}, 32'(o_rdata), 0);
    check({tag, ".full"}, 32'(o_full), 0);
    check({tag, ".drop"}, 32'(o_drop), 0);
    check({tag, ".be"}, 32'(o_avm_byteenable), 3);
  endtask

  initial begin
    i_rst_n = 1'b0; i_write = 1'b0; i_read = 1'b0; i_addr = '0; i_wdata = '0;
    i_avm_waitrequest = 1'b0; i_avm_readdata = '0; i_avm_readdatavalid = 1'b0;
    tick(); tick();
    check_idle_outputs("rst");
    i_rst_n = 1'b1;
    tick();

    // Single write, no waitrequest: strobe one cycle, two edges after request.
    i_write = 1'b1; i_addr = 26'h5; i_wdata = 16'hBEEF;
    tick();
    i_write = 1'b0;
    check("wr1.lat", 32'(o_avm_write), 0);
    tick();
    check("wr1.write", 32'(o_avm_write), 1);
    check("wr1.addr", 32'(o_avm_address), 'h5);
    check("wr1.data", 32'(o_avm_writedata), 'hBEEF);
    check("wr1.be", 32'(o_avm_byteenable), 3);
    tick();
    check("wr1.end", 32'(o_avm_write), 0);

    // Same write stalled by three cycles of waitrequest.
    i_avm_waitrequest = 1'b1;
    i_write = 1'b1;
    tick();
    i_write = 1'b0;
    tick();
    check("wr2.hold0", 32'(o_avm_write), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("wr2.hold%0d", i), 32'(o_avm_write), 1);
      check($sformatf("wr2.addr%0d", i), 32'(o_avm_address), 'h5);
      check($sformatf("wr2.data%0d", i), 32'(o_avm_writedata), 'hBEEF);
    end
    i_avm_waitrequest = 1'b0;
    tick();
    check("wr2.end", 32'(o_avm_write), 0);

    // Read at top address, returned three cycles after acceptance.
    i_read = 1'b1; i_addr = 26'h3FFFFFF;
    tick();
    i_read = 1'b0;
    tick();
    check("rd1.read", 32'(o_avm_read), 1);
    check("rd1.addr", 32'(o_avm_address), 'h3FFFFFF);
    tick();
    check("rd1.end", 32'(o_avm_read), 0);
    i_avm_readdatavalid = 1'b1; i_avm_readdata = 16'h1234;
    tick();
    i_avm_readdatavalid = 1'b0;
    check("rd1.rvalid", 32'(o_rvalid), 1);
    check("rd1.rdata", 32'(o_rdata), 'h1234);
    tick();
    check("rd1.pulse", 32'(o_rvalid), 0);
    check("rd1.pend", 32'(dut.pend_q), 0);

    // Fill: a stalled blocker occupies the bus, then five write pulses.
    i_avm_waitrequest = 1'b1;
    i_write = 1'b1; i_addr = 26'hFF; i_wdata = 16'h0FFF;
    tick();
    i_write = 1'b0;
    tick();
    check("fill.blocker", 32'(o_avm_address), 'hFF);
    for (int i = 0; i < 5; i++) begin
      i_write = 1'b1; i_addr = 26'(32'h100 + i); i_wdata = 16'(32'h1000 + i);
      tick();
      check($sformatf("fill.drop%0d", i), 32'(o_drop), (i == 4) ? 1 : 0);
      check($sformatf("fill.full%0d", i), 32'(o_full), (i >= 3) ? 1 : 0);
    end
    i_write = 1'b0;
    tick();
    check("fill.droplow", 32'(o_drop), 0);
    i_avm_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fill.wr%0d", i), 32'(o_avm_write), 1);
      check($sformatf("fill.addr%0d", i), 32'(o_avm_address), 32'h100 + i);
      check($sformatf("fill.data%0d", i), 32'(o_avm_writedata), 32'h1000 + i);
    end
    tick();
    check("fill.end", 32'(o_avm_write), 0);
    check("fill.unfull", 32'(o_full), 0);

    // Simultaneous write and read: write kept, read dropped.
    i_write = 1'b1; i_read = 1'b1; i_addr = 26'h10; i_wdata = 16'hA5A5;
    tick();
    i_write = 1'b0; i_read = 1'b0;
    check("both.drop", 32'(o_drop), 1);
    tick();
    check("both.write", 32'(o_avm_write), 1);
    check("both.read", 32'(o_avm_read), 0);
    check("both.addr", 32'(o_avm_address), 'h10);
    check("both.data", 32'(o_avm_writedata), 'hA5A5);
    check("both.droplow", 32'(o_drop), 0);
    tick();
    check("both.endw", 32'(o_avm_write), 0);
    check("both.endr", 32'(o_avm_read), 0);

    // Five reads with returns withheld: the fifth waits for a credit.
    for (int i = 0; i < 5; i++) begin
      i_read = 1'b1; i_addr = 26'(32'h200 + i);
      tick();
      if (i > 0) begin
        check($sformatf("pend.rd%0d", i - 1), 32'(o_avm_read), 1);
        check($sformatf("pend.addr%0d", i - 1), 32'(o_avm_address), 32'h200 + i - 1);
      end
    end
    i_read = 1'b0;
    tick();
    check("pend.stallA", 32'(o_avm_read), 0);
    check("pend.cnt4", 32'(dut.pend_q), 4);
    tick();
    check("pend.stallB", 32'(o_avm_read), 0);
    i_avm_readdatavalid = 1'b1; i_avm_readdata = 16'hD000;
    tick();
    i_avm_readdatavalid = 1'b0;
    check("pend.ret0v", 32'(o_rvalid), 1);
    check("pend.ret0d", 32'(o_rdata), 'hD000);
    check("pend.stallC", 32'(o_avm_read), 0);
    tick();
    check("pend.rd4", 32'(o_avm_read), 1);
    check("pend.addr4", 32'(o_avm_address), 'h204);
    check("pend.ret0end", 32'(o_rvalid), 0);
    tick();
    check("pend.rd4end", 32'(o_avm_read), 0);
    for (int i = 1; i < 5; i++) begin
      i_avm_readdatavalid = 1'b1; i_avm_readdata = 16'(32'hD000 + i);
      tick();
      check($sformatf("pend.ret%0dv", i), 32'(o_rvalid), 1);
      check($sformatf("pend.ret%0dd", i), 32'(o_rdata), 32'hD000 + i);
    end
    i_avm_readdatavalid = 1'b0;
    tick();
    check("pend.zero", 32'(dut.pend_q), 0);
    // Stray readdatavalid with nothing pending must be ignored.
    i_avm_readdatavalid = 1'b1;
    tick();
    i_avm_readdatavalid = 1'b0;
    check("stray.rvalid", 32'(o_rvalid), 0);
    check("stray.pend", 32'(dut.pend_q), 0);

    // Reset with one read returned-pending and a second stalled on the bus.
    i_read = 1'b1; i_addr = 26'h300;
    tick();
    i_read = 1'b0;
    tick();
    tick();
    check("arst.pend1", 32'(dut.pend_q), 1);
    i_avm_waitrequest = 1'b1;
    i_read = 1'b1; i_addr = 26'h301;
    tick();
    i_read = 1'b0;
    tick();
    check("arst.busy", 32'(o_avm_read), 1);
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    check("arst.pend", 32'(dut.pend_q), 0);
    i_avm_waitrequest = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    i_avm_readdatavalid = 1'b1; i_avm_readdata = 16'h7777;
    tick();
    i_avm_readdatavalid = 1'b0;
    check("arst.rvalid", 32'(o_rvalid), 0);
    i_write = 1'b1; i_addr = 26'h55; i_wdata = 16'h1111;
    tick();
    i_write = 1'b0;
    check("arst.lat", 32'(o_avm_write), 0);
    tick();
    check("arst.write", 32'(o_avm_write), 1);
    check("arst.addr", 32'(o_avm_address), 'h55);
    check("arst.data", 32'(o_avm_writedata), 'h1111);
    tick();
    check("arst.end", 32'(o_avm_write), 0);
    check("arst.rv2", 32'(o_rvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
